// File: rtl/inst_dispatch.sv
// ---------------------------------------------------------------------------
// inst_dispatch: decodes one instruction per pulse, launches DMA/MMU, awaits done. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_dispatch #(
  parameter int INST_BITS      = 128,
  parameter int ADDR_BITS      = 32,
  parameter int LEN_BITS       = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [INST_BITS-1:0] instruction,
  input  logic                 init_inst_pulse,
  output logic                 flag,
  output logic                 idle_flag,
  output logic                 dma_start,
  output logic                 dma_dir,
  output logic [ADDR_BITS-1:0] dma_src,
  output logic [ADDR_BITS-1:0] dma_dst,
  output logic [LEN_BITS-1:0]  dma_len,
  input  logic                 dma_done,
  output logic                 mmu_start,
  output logic [LEN_BITS-1:0]  mmu_len,
  input  logic                 mmu_done,
  output logic                 halted,
  output logic [2:0]           err
);
  localparam int OP_LSB  = INST_BITS - 4;
  localparam int A_LSB   = OP_LSB - ADDR_BITS;
  localparam int B_LSB   = A_LSB - ADDR_BITS;
  localparam int L_LSB   = B_LSB - LEN_BITS;
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_LOAD    = 4'd1;
  localparam logic [3:0] OP_STORE   = 4'd2;
  localparam logic [3:0] OP_COMPUTE = 4'd3;
  localparam logic [3:0] OP_HALT    = 4'd15;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  logic [2:0]           state, state_nxt;
  logic [3:0]           op_q;
  logic [ADDR_BITS-1:0] addra_q, addrb_q;
  logic [LEN_BITS-1:0]  len_q;
  logic [WD_BITS-1:0]   wd_cnt;
  logic                 is_dma, is_mmu, is_illegal, done_match, wd_expire, pulse_dropped;
  logic                 unused_bits;

  assign unused_bits   = ^instruction[L_LSB-1:0];
  assign is_dma        = (op_q == OP_LOAD) || (op_q == OP_STORE);
  assign is_mmu        = (op_q == OP_COMPUTE);
  assign is_illegal    = !is_dma && !is_mmu && (op_q != OP_NOP) && (op_q != OP_HALT);
  assign done_match    = is_mmu ? mmu_done : dma_done;
  assign wd_expire     = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);
  assign pulse_dropped = init_inst_pulse && (state != S_IDLE) && (state != S_HALTED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (init_inst_pulse) state_nxt = S_DECODE;
      S_DECODE: state_nxt = (is_dma || is_mmu) ? S_ISSUE : S_DONE;
      S_ISSUE:  state_nxt = S_WAIT;
      // A matching done on the watchdog's last cycle still counts as success
      S_WAIT:   if (done_match || wd_expire) state_nxt = S_DONE;
      S_DONE:   state_nxt = halted ? S_HALTED : S_IDLE;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    flag      = (state == S_DONE);
    idle_flag = (state == S_IDLE);
    dma_start = (state == S_ISSUE) && is_dma;
    mmu_start = (state == S_ISSUE) && is_mmu;
  end

  assign dma_dir = (op_q == OP_STORE);
  assign dma_src = addra_q;
  assign dma_dst = addrb_q;
  assign dma_len = len_q;
  assign mmu_len = len_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= '0;
      addra_q <= '0;
      addrb_q <= '0;
      len_q   <= '0;
    end else if (state == S_IDLE && init_inst_pulse) begin
      op_q    <= instruction[OP_LSB +: 4];
      addra_q <= instruction[A_LSB +: ADDR_BITS];
      addrb_q <= instruction[B_LSB +: ADDR_BITS];
      len_q   <= instruction[L_LSB +: LEN_BITS];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT && wd_cnt != {WD_BITS{1'b1}}) begin
      wd_cnt <= wd_cnt + WD_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err    <= 3'b000;
      halted <= 1'b0;
    end else begin
      if (pulse_dropped)                                 err[0] <= 1'b1;
      if (state == S_DECODE && is_illegal)               err[1] <= 1'b1;
      if (state == S_WAIT && wd_expire && !done_match)   err[2] <= 1'b1;
      if (state == S_DECODE && op_q == OP_HALT)          halted <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_dispatch.sv
// ---------------------------------------------------------------------------
// tb_inst_dispatch: randomized scoreboard bench for inst_dispatch. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_inst_dispatch;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [127:0] instruction = '0;
  logic         init_inst_pulse = 1'b0, dma_done = 1'b0, mmu_done = 1'b0;
  logic         flag, idle_flag, dma_start, dma_dir, mmu_start, halted;
  logic [31:0]  dma_src, dma_dst;
  logic [15:0]  dma_len, mmu_len;
  logic [2:0]   err;

  inst_dispatch #(.INST_BITS(128), .ADDR_BITS(32), .LEN_BITS(16), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .init_inst_pulse(init_inst_pulse),
    .flag(flag), .idle_flag(idle_flag), .dma_start(dma_start), .dma_dir(dma_dir),
    .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len), .dma_done(dma_done),
    .mmu_start(mmu_start), .mmu_len(mmu_len), .mmu_done(mmu_done),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = no engine, 1 = memory mover, 2 = MMU
  typedef struct {
    int        e0;
    int        fc;
    int        kind;
    bit        dir;
    bit [31:0] src;
    bit [31:0] dst;
    bit [15:0] len;
    bit [2:0]  err;
    bit        halt;
  } exp_t;

  exp_t     q[$];
  bit       head_started = 1'b0;
  bit       halted_seen = 1'b0;
  bit [2:0] err_model = 3'b000;
  int       vecs = 0, miscompares = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  initial begin : monitor
    exp_t r;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("idle_flag", idle_flag, !halted_seen && (q.size() == 0 || cyc < q[0].e0));
        if (dma_start || mmu_start) begin
          if (q.size() == 0 || q[0].kind == 0 || head_started) begin
            chk("start_unexpected", {dma_start, mmu_start}, 2'b00);
          end else begin
            head_started = 1'b1;
            chk("start_cycle", cyc, q[0].e0 + 1);
            chk("start_kind", {dma_start, mmu_start}, (q[0].kind == 1) ? 2'b10 : 2'b01);
            if (q[0].kind == 1) chk("dma_dir", dma_dir, q[0].dir);
          end
        end
        if (q.size() > 0 && q[0].kind != 0 && cyc > q[0].e0) begin
          if (q[0].kind == 1) begin
            chk("dma_src", dma_src, q[0].src);
            chk("dma_dst", dma_dst, q[0].dst);
            chk("dma_len", dma_len, q[0].len);
          end else begin
            chk("mmu_len", mmu_len, q[0].len);
          end
        end
        if (q.size() > 0 && (flag || cyc >= q[0].fc)) begin
          r = q.pop_front();
          chk("flag", flag, 1'b1);
          chk("flag_cycle", cyc, r.fc);
          chk("err_at_flag", err, r.err);
          chk("halted_at_flag", halted, r.halt);
          chk("start_seen", head_started, r.kind != 0);
          head_started = 1'b0;
          if (r.halt) halted_seen = 1'b1;
        end else if (flag) begin
          chk("flag_unexpected", flag, 1'b0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      init_inst_pulse = 1'b0;
      dma_done = 1'b0;
      mmu_done = 1'b0;
      instruction = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // d: WAIT cycle on which the matching done is sampled (1..T), 0 = never
  task automatic run_inst(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [15:0] l, input int d, input bit spur, input bit early,
                          input bit drop_w, input bit drop_f);
    exp_t r;
    int lat, kw, ks;
    logic [127:0] word;
    logic md, nm;
    word = {op, a, b, l, 12'($urandom), 32'($urandom)};
    @(posedge clk); #1;
    r.e0   = cyc + 1;
    r.kind = (op == 4'd1 || op == 4'd2) ? 1 : ((op == 4'd3) ? 2 : 0);
    r.dir  = (op == 4'd2);
    r.src  = a;
    r.dst  = b;
    r.len  = l;
    lat    = (r.kind == 0) ? 1 : ((d == 0) ? 2 + T : 2 + d);
    r.fc   = r.e0 + lat;
    r.err  = err_model | {(r.kind != 0) && (d == 0), (op >= 4'd4) && (op <= 4'd14), drop_w};
    r.halt = (op == 4'd15);
    err_model = r.err | {2'b00, drop_f};
    q.push_back(r);
    kw = $urandom_range(lat, 1);
    ks = $urandom_range(lat + 1, 2);
    for (int k = 0; k <= lat + 1; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      init_inst_pulse = (k == 0) || (drop_w && k == kw) || (drop_f && k == lat + 1);
      instruction = (k == 0) ? word : {$urandom, $urandom, $urandom, $urandom};
      md = (r.kind != 0) && (((d != 0) && (k == 2 + d)) || (early && k == 2));
      nm = (r.kind != 0) && spur && (k == ks);
      dma_done = (r.kind == 2) ? nm : md;
      mmu_done = (r.kind == 2) ? md : nm;
    end
  endtask

  task automatic check_reset_values();
    chk("rst_flag", flag, 1'b0);
    chk("rst_idle_flag", idle_flag, 1'b1);
    chk("rst_dma_start", dma_start, 1'b0);
    chk("rst_mmu_start", mmu_start, 1'b0);
    chk("rst_dma_dir", dma_dir, 1'b0);
    chk("rst_dma_src", dma_src, 32'h0);
    chk("rst_dma_dst", dma_dst, 32'h0);
    chk("rst_dma_len", dma_len, 16'h0);
    chk("rst_mmu_len", mmu_len, 16'h0);
    chk("rst_err", err, 3'b000);
    chk("rst_halted", halted, 1'b0);
  endtask

  initial begin : driver
    exp_t r;
    repeat (3) @(negedge clk);
    check_reset_values();
    @(posedge clk); #2 reset_n = 1'b1;
    idle(5);

    run_inst(4'd0, $urandom, $urandom, 16'($urandom), 0, 0, 0, 0, 0);
    run_inst(4'd1, 32'h4000_0000, 32'h0000_0010, 16'd16, 5, 0, 0, 0, 0);
    idle(2);
    run_inst(4'd3, $urandom, $urandom, 16'd8, 6, 1, 0, 0, 0);
    run_inst(4'd2, $urandom, $urandom, 16'd20, 0, 0, 0, 0, 0);
    run_inst(4'd0, $urandom, $urandom, 16'($urandom), 0, 0, 0, 0, 0);
    run_inst(4'd1, $urandom, $urandom, 16'($urandom), 3, 0, 0, 1, 1);
    run_inst(4'd7, $urandom, $urandom, 16'($urandom), 0, 0, 0, 0, 0);
    run_inst(4'd3, $urandom, $urandom, 16'd0, T, 1, 1, 0, 0);
    run_inst(4'd2, $urandom, $urandom, 16'd0, 1, 0, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int sel, op, d;
      sel = $urandom_range(9, 0);
      op  = (sel < 4) ? sel : ((sel < 7) ? $urandom_range(3, 1) : $urandom_range(14, 4));
      d   = ($urandom_range(9, 0) == 0) ? 0 :
            (($urandom_range(4, 0) == 0) ? $urandom_range(T, T - 1) : $urandom_range(6, 1));
      run_inst(4'(op), $urandom, $urandom, 16'($urandom), d, $urandom_range(3, 0) == 0,
               $urandom_range(3, 0) == 0, $urandom_range(4, 0) == 0, $urandom_range(4, 0) == 0);
      if ($urandom_range(2, 0) == 0) idle($urandom_range(3, 1));
    end
    idle(3);

    run_inst(4'd15, $urandom, $urandom, 16'($urandom), 0, 0, 0, 0, 0);
    repeat (6) begin
      @(posedge clk); #1;
      init_inst_pulse = 1'b1;
      instruction = {$urandom, $urandom, $urandom, $urandom};
      instruction[127:124] = 4'($urandom_range(3, 0));
    end
    idle(4);
    @(negedge clk);
    chk("halted_sticky", halted, 1'b1);
    chk("err_after_halt", err, err_model);

    @(posedge clk); #3 reset_n = 1'b0;
    #1 check_reset_values();
    q.delete();
    head_started = 1'b0;
    halted_seen  = 1'b0;
    err_model    = 3'b000;
    @(posedge clk); #2 reset_n = 1'b1;
    idle(2);

    @(posedge clk); #1;
    r.e0 = cyc + 1; r.fc = r.e0 + 100; r.kind = 1; r.dir = 1'b0;
    r.src = 32'hA5A5_0000; r.dst = 32'h0000_1234; r.len = 16'd99; r.err = 3'b000; r.halt = 1'b0;
    q.push_back(r);
    init_inst_pulse = 1'b1;
    instruction = {4'd1, 32'hA5A5_0000, 32'h0000_1234, 16'd99, 12'($urandom), 32'($urandom)};
    @(posedge clk); #1;
    init_inst_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_reset_values();
    chk("start_before_reset", head_started, 1'b1);
    q.delete();
    head_started = 1'b0;
    @(posedge clk); #2 reset_n = 1'b1;
    idle(1);
    @(posedge clk); #1 dma_done = 1'b1;
    idle(8);
    @(negedge clk);
    chk("post_reset_flag", flag, 1'b0);
    chk("post_reset_idle", idle_flag, 1'b1);
    chk("post_reset_err", err, 3'b000);
    chk("post_reset_halted", halted, 1'b0);
    chk("outstanding", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
